// File: rtl/addsub_serial_ctrl.sv
// addsub_serial_ctrl: nibble-serial wide add/subtract controller.
// One 4-bit slice is reused NIBBLES times, LS nibble first, with the
// inter-nibble carry held in a register. Requests and results each use
// a valid/ready handshake; the result is held stable until it is taken.

// 4-bit add/subtract slice. On subtract b is inverted here and the caller
// injects the +1 through cin. c3 is the carry into bit 3, which the
// controller uses to derive signed overflow on the top nibble.
module addsub_nibble (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       sub,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       c3
);
   logic [3:0] b_eff;
   logic [3:0] lo;
   logic [4:0] full;

   assign b_eff = b ^ {4{sub}};
   assign lo    = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
   assign full  = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
   assign sum   = full[3:0];
   assign cout  = full[4];
   assign c3    = lo[3];
endmodule

module addsub_serial_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   ovf,
   output logic                   zero
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             mode_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic [W-1:0]     result_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             in_ready_q;
   logic             out_valid_q;

   // Slice operand selection for the nibble currently being processed.
   logic [IDX_W+1:0] nib_lsb;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       nib_sum;
   logic             nib_cout;
   logic             nib_c3;
   logic [W-1:0]     res_next;

   assign nib_lsb = {idx_q, 2'b00};
   assign a_nib   = a_q[nib_lsb +: 4];
   assign b_nib   = b_q[nib_lsb +: 4];

   addsub_nibble u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .sub  (mode_q),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout),
      .c3   (nib_c3)
   );

   // Result word with the current nibble merged in; on the last nibble this
   // is the complete answer, so the zero flag is taken from it directly.
   always_comb begin
      res_next = result_q;
      res_next[nib_lsb +: 4] = nib_sum;
   end

   // Control FSM with operand/carry/result registers and registered handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= 1'b0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  mode_q     <= mode;
                  carry_q    <= mode;  // +1 of the two's complement on subtract
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               result_q <= res_next;
               carry_q  <= nib_cout;
               idx_q    <= idx_q + IDX_W'(1);
               if (idx_q == LAST) begin
                  cout_q      <= nib_cout;
                  ovf_q       <= nib_c3 ^ nib_cout;
                  zero_q      <= (res_next == '0);
                  idx_q       <= '0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
endmodule
